// File: rtl/video_ddr_out_gen.sv
// rtl/video_ddr_out_gen.sv - ADV7511 output stage: input sync, divided pixel clock, DDR half-word framing, colour bars
`timescale 1ns/1ps
module video_ddr_out_gen #(
  parameter int BPC         = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CLK_DIV     = 4,
  parameter int PHASE       = 1,
  parameter bit HSYNC_INV   = 1'b0,
  parameter bit VSYNC_INV   = 1'b0,
  parameter int BAR_SHIFT   = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_de,
  input  logic               i_hsync,
  input  logic               i_vsync,
  input  logic [BPC-1:0]     i_r,
  input  logic [BPC-1:0]     i_g,
  input  logic [BPC-1:0]     i_b,
  input  logic               i_test_pattern,
  output logic               o_clk_pixel,
  output logic               o_pix_stb,
  output logic               o_de,
  output logic               o_hsync,
  output logic               o_vsync,
  output logic [3*BPC/2-1:0] o_data,
  output logic               o_test_active
);
  localparam int W  = 3 * BPC;
  localparam int H  = W / 2;
  localparam int SW = W + 4;
  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(CLK_DIV / 2 - 1);

  logic [SYNC_STAGES-1:0][SW-1:0] sync_q;
  logic          s_tp, s_vs, s_hs, s_de;
  logic [W-1:0]  s_rgb;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          wrap, mid, clk_pix_d;
  int            ph;

  logic [11:0]   x_q, x_d;
  logic          vs_prev_q, test_active_q, tp_use;
  logic [2:0]    bar;
  logic [W-1:0]  bar_rgb, word;
  logic [H-1:0]  hi_q, data_q;
  logic          de_q, hs_q, vs_q, clk_pix_q, stb_q;

  // Every input bit, including the pattern request, goes through the same chain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= {i_test_pattern, i_vsync, i_hsync, i_de, i_r, i_g, i_b};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign {s_tp, s_vs, s_hs, s_de, s_rgb} = sync_q[SYNC_STAGES-1];

  always_comb begin
    wrap      = (cnt_q == CNT_LAST);
    mid       = (cnt_q == CNT_MID);
    cnt_d     = wrap ? '0 : cnt_q + 1'b1;
    // Clock is registered from cnt_d so it lines up with the cnt value it encodes
    ph        = (int'(cnt_d) + CLK_DIV - PHASE) % CLK_DIV;
    clk_pix_d = (ph < CLK_DIV / 2);
  end

  always_comb begin
    // A vsync rise in this very pixel selects the new pattern state immediately
    tp_use  = (s_vs && !vs_prev_q) ? s_tp : test_active_q;
    bar     = x_q[BAR_SHIFT+2:BAR_SHIFT];
    bar_rgb = {{BPC{bar[2]}}, {BPC{bar[1]}}, {BPC{bar[0]}}};
    word    = '0;
    if (s_de) word = tp_use ? bar_rgb : s_rgb;
    x_d     = s_de ? x_q + 12'd1 : 12'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q         <= '0;
      clk_pix_q     <= 1'b0;
      stb_q         <= 1'b0;
      x_q           <= '0;
      vs_prev_q     <= 1'b0;
      test_active_q <= 1'b0;
      hi_q          <= '0;
      data_q        <= '0;
      de_q          <= 1'b0;
      hs_q          <= HSYNC_INV;
      vs_q          <= VSYNC_INV;
    end else begin
      cnt_q     <= cnt_d;
      clk_pix_q <= clk_pix_d;
      stb_q     <= wrap;
      if (wrap) begin
        x_q           <= x_d;
        vs_prev_q     <= s_vs;
        test_active_q <= tp_use;
        de_q          <= s_de;
        hs_q          <= s_hs ^ HSYNC_INV;
        vs_q          <= s_vs ^ VSYNC_INV;
        data_q        <= word[H-1:0];
        hi_q          <= word[W-1:H];
      end else if (mid) begin
        data_q <= hi_q;
      end
    end
  end

  assign o_clk_pixel   = clk_pix_q;
  assign o_pix_stb     = stb_q;
  assign o_de          = de_q;
  assign o_hsync       = hs_q;
  assign o_vsync       = vs_q;
  assign o_data        = data_q;
  assign o_test_active = test_active_q;

endmodule

// File: tb/tb_video_ddr_out_gen.sv
// tb/tb_video_ddr_out_gen.sv - directed self-checking bench for video_ddr_out_gen
`timescale 1ns/1ps
module tb_video_ddr_out_gen;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        a_de = 1'b0, a_hs = 1'b0, a_vs = 1'b0, a_tp = 1'b0;
  logic [7:0]  a_r = '0, a_g = '0, a_b = '0;
  logic        a_clk_pixel, a_stb, a_ode, a_ohs, a_ovs, a_act;
  logic [11:0] a_data;

  logic        b_de = 1'b0, b_hs = 1'b0, b_vs = 1'b0, b_tp = 1'b0;
  logic [9:0]  b_r = '0, b_g = '0, b_b = '0;
  logic        b_clk_pixel, b_stb, b_ode, b_ohs, b_ovs, b_act;
  logic [14:0] b_data;

  int cyc = 0;
  int n_assert = 0;
  int n_fail = 0;

  // Clock edges since reset release; cnt of each instance is cyc mod its CLK_DIV
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  video_ddr_out_gen #(.BPC(8), .SYNC_STAGES(2), .CLK_DIV(4), .PHASE(1),
                      .HSYNC_INV(1'b1), .VSYNC_INV(1'b0), .BAR_SHIFT(7)) dut (
    .clk(clk), .rst(rst), .i_de(a_de), .i_hsync(a_hs), .i_vsync(a_vs),
    .i_r(a_r), .i_g(a_g), .i_b(a_b), .i_test_pattern(a_tp),
    .o_clk_pixel(a_clk_pixel), .o_pix_stb(a_stb), .o_de(a_ode),
    .o_hsync(a_ohs), .o_vsync(a_ovs), .o_data(a_data), .o_test_active(a_act));

  video_ddr_out_gen #(.BPC(10), .SYNC_STAGES(3), .CLK_DIV(6), .PHASE(2),
                      .HSYNC_INV(1'b0), .VSYNC_INV(1'b0), .BAR_SHIFT(7)) dut_b (
    .clk(clk), .rst(rst), .i_de(b_de), .i_hsync(b_hs), .i_vsync(b_vs),
    .i_r(b_r), .i_g(b_g), .i_b(b_b), .i_test_pattern(b_tp),
    .o_clk_pixel(b_clk_pixel), .o_pix_stb(b_stb), .o_de(b_ode),
    .o_hsync(b_ohs), .o_vsync(b_ovs), .o_data(b_data), .o_test_active(b_act));

  task automatic test_reset();
    int ka, kb;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_assert++;
    if ({a_clk_pixel, a_stb, a_ode, a_ohs, a_ovs, a_act} !== 6'b000100) begin
      n_fail++; $display("FAIL reset_ctrl_a: got %b expected 000100", {a_clk_pixel, a_stb, a_ode, a_ohs, a_ovs, a_act});
    end
    n_assert++;
    if (a_data !== 12'h000) begin n_fail++; $display("FAIL reset_data_a: got %h expected 000", a_data); end
    n_assert++;
    if ({b_clk_pixel, b_stb, b_ode, b_ohs, b_ovs, b_act, b_data} !== 21'h0) begin
      n_fail++; $display("FAIL reset_b: got %h expected 0", {b_clk_pixel, b_stb, b_ode, b_ohs, b_ovs, b_act, b_data});
    end
    rst = 1'b0;
    ka = 0; kb = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (a_stb === 1'b1 && ka == 0) ka = k;
      if (b_stb === 1'b1 && kb == 0) kb = k;
    end
    n_assert++;
    if (ka != 4) begin n_fail++; $display("FAIL first_stb_a: got cycle %0d expected 4", ka); end
    n_assert++;
    if (kb != 6) begin n_fail++; $display("FAIL first_stb_b: got cycle %0d expected 6", kb); end
  endtask

  task automatic test_clock();
    logic ea_clk, ea_stb, eb_clk, eb_stb;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      ea_clk = (cyc % 4 == 1) || (cyc % 4 == 2);
      ea_stb = (cyc % 4 == 0);
      eb_clk = (cyc % 6 >= 2) && (cyc % 6 <= 4);
      eb_stb = (cyc % 6 == 0);
      n_assert++;
      if (a_clk_pixel !== ea_clk) begin n_fail++; $display("FAIL clk_pixel_a cyc%0d: got %b expected %b", cyc, a_clk_pixel, ea_clk); end
      n_assert++;
      if (a_stb !== ea_stb) begin n_fail++; $display("FAIL pix_stb_a cyc%0d: got %b expected %b", cyc, a_stb, ea_stb); end
      n_assert++;
      if (b_clk_pixel !== eb_clk) begin n_fail++; $display("FAIL clk_pixel_b cyc%0d: got %b expected %b", cyc, b_clk_pixel, eb_clk); end
      n_assert++;
      if (b_stb !== eb_stb) begin n_fail++; $display("FAIL pix_stb_b cyc%0d: got %b expected %b", cyc, b_stb, eb_stb); end
    end
  endtask

  task automatic test_ddr_split(input logic [23:0] rgb, input logic [11:0] lo, input logic [11:0] hi);
    int n;
    bit found;
    logic [11:0] exp;
    @(negedge clk);
    {a_r, a_g, a_b} = rgb; a_de = 1'b1; a_hs = 1'b0; a_vs = 1'b0;
    n = 0; found = 0;
    while (!found && n < 12) begin
      @(negedge clk); n++;
      if (a_ode === 1'b1 && a_data === lo) found = 1;
    end
    n_assert++;
    if (!found || n > 6) begin n_fail++; $display("FAIL ddr_latency %h: got %0d cycles (found=%0d) expected <=6", rgb, n, found); end
    n_assert++;
    if (cyc % 4 != 0) begin n_fail++; $display("FAIL ddr_low_phase %h: got cnt %0d expected 0", rgb, cyc % 4); end
    n_assert++;
    if (a_ohs !== 1'b1) begin n_fail++; $display("FAIL ddr_hsync %h: got %b expected 1", rgb, a_ohs); end
    for (int j = 1; j < 4; j++) begin
      @(negedge clk);
      exp = (j < 2) ? lo : hi;
      n_assert++;
      if (a_data !== exp) begin n_fail++; $display("FAIL ddr_word %h step%0d: got %h expected %h", rgb, j, a_data, exp); end
    end
  endtask

  task automatic test_blank();
    @(negedge clk);
    a_de = 1'b0; a_hs = 1'b1; a_vs = 1'b1; {a_r, a_g, a_b} = 24'hFFFFFF;
    repeat (12) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_assert++;
      if (a_data !== 12'h000) begin n_fail++; $display("FAIL blank_data: got %h expected 000", a_data); end
      n_assert++;
      if ({a_ode, a_ohs, a_ovs} !== 3'b001) begin n_fail++; $display("FAIL blank_ctrl: got %b expected 001", {a_ode, a_ohs, a_ovs}); end
    end
    a_hs = 1'b0; a_vs = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_pattern();
    int guard, idx, seen;
    bit chk;
    logic [11:0] lo;
    logic [23:0] got, exp;
    @(negedge clk);
    a_tp = 1'b1; a_de = 1'b1; {a_r, a_g, a_b} = 24'h123456;
    repeat (12) @(negedge clk);
    guard = 0;
    while (cyc % 4 != 0 && guard < 8) begin @(negedge clk); guard++; end
    n_assert++;
    if (a_act !== 1'b0) begin n_fail++; $display("FAIL tp_midframe_active: got %b expected 0", a_act); end
    n_assert++;
    if (a_data !== 12'h456) begin n_fail++; $display("FAIL tp_midframe_lo: got %h expected 456", a_data); end
    repeat (2) @(negedge clk);
    n_assert++;
    if (a_data !== 12'h123) begin n_fail++; $display("FAIL tp_midframe_hi: got %h expected 123", a_data); end
    a_de = 1'b0; a_vs = 1'b1;
    repeat (12) @(negedge clk);
    n_assert++;
    if (a_act !== 1'b1) begin n_fail++; $display("FAIL tp_vsync_load: got %b expected 1", a_act); end
    a_vs = 1'b0;
    repeat (12) @(negedge clk);
    a_de = 1'b1;
    idx = -1; seen = 0; lo = '0;
    for (int k = 0; k < 4000 && seen < 5; k++) begin
      @(negedge clk);
      if (cyc % 4 == 0 && a_ode === 1'b1) begin
        idx++; lo = a_data;
      end else if (cyc % 4 == 2 && idx >= 0) begin
        got = {a_data, lo};
        chk = 1'b1; exp = 24'h000000;
        case (idx)
          0, 127: exp = 24'h000000;
          128:    exp = 24'h0000FF;
          384:    exp = 24'h00FFFF;
          896:    exp = 24'hFFFFFF;
          default: chk = 1'b0;
        endcase
        if (chk) begin
          n_assert++; seen++;
          if (got !== exp) begin n_fail++; $display("FAIL bar_x%0d: got %h expected %h", idx, got, exp); end
        end
      end
    end
    n_assert++;
    if (seen != 5) begin n_fail++; $display("FAIL bar_timeout: got %0d bars checked expected 5", seen); end
  endtask

  task automatic test_reset_mid();
    int guard, ka;
    guard = 0;
    @(negedge clk);
    while (cyc % 4 != 2 && guard < 8) begin @(negedge clk); guard++; end
    n_assert++;
    if ({a_clk_pixel, a_ode, a_act} !== 3'b111) begin n_fail++; $display("FAIL pre_reset_state: got %b expected 111", {a_clk_pixel, a_ode, a_act}); end
    #2 rst = 1'b1;
    #1;
    n_assert++;
    if ({a_clk_pixel, a_stb, a_ode, a_ohs, a_ovs, a_act} !== 6'b000100) begin
      n_fail++; $display("FAIL midreset_ctrl: got %b expected 000100", {a_clk_pixel, a_stb, a_ode, a_ohs, a_ovs, a_act});
    end
    n_assert++;
    if (a_data !== 12'h000) begin n_fail++; $display("FAIL midreset_data: got %h expected 000", a_data); end
    @(negedge clk);
    rst = 1'b0;
    ka = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (a_stb === 1'b1 && ka == 0) ka = k;
    end
    n_assert++;
    if (ka != 4) begin n_fail++; $display("FAIL midreset_first_stb: got cycle %0d expected 4", ka); end
  endtask

  task automatic test_vsync_same_pixel();
    int n;
    bit found;
    @(negedge clk);
    a_tp = 1'b1; a_de = 1'b0; a_vs = 1'b0;
    repeat (12) @(negedge clk);
    a_vs = 1'b1;
    repeat (12) @(negedge clk);
    n_assert++;
    if (a_act !== 1'b1) begin n_fail++; $display("FAIL same_px_setup: got %b expected 1", a_act); end
    a_vs = 1'b0;
    repeat (12) @(negedge clk);
    a_tp = 1'b0;
    repeat (12) @(negedge clk);
    a_de = 1'b1; a_vs = 1'b1; {a_r, a_g, a_b} = 24'h123456;
    n = 0; found = 0;
    while (!found && n < 12) begin
      @(negedge clk); n++;
      if (cyc % 4 == 0 && a_ode === 1'b1) found = 1;
    end
    n_assert++;
    if (!found) begin n_fail++; $display("FAIL same_px_timeout: got no pixel expected one within 12"); end
    n_assert++;
    if (a_data !== 12'h456) begin n_fail++; $display("FAIL same_px_data: got %h expected 456", a_data); end
    n_assert++;
    if (a_act !== 1'b0) begin n_fail++; $display("FAIL same_px_active: got %b expected 0", a_act); end
    a_de = 1'b0; a_vs = 1'b0;
  endtask

  task automatic test_params();
    int n;
    bit found;
    logic [14:0] exp;
    @(negedge clk);
    b_r = 10'h2A5; b_g = 10'h13C; b_b = 10'h396; b_de = 1'b1;
    n = 0; found = 0;
    while (!found && n < 14) begin
      @(negedge clk); n++;
      if (b_ode === 1'b1 && b_data === 15'h7396) found = 1;
    end
    n_assert++;
    if (!found || n > 9) begin n_fail++; $display("FAIL params_latency: got %0d cycles (found=%0d) expected <=9", n, found); end
    n_assert++;
    if (cyc % 6 != 0) begin n_fail++; $display("FAIL params_low_phase: got cnt %0d expected 0", cyc % 6); end
    for (int j = 1; j < 6; j++) begin
      @(negedge clk);
      exp = (j < 3) ? 15'h7396 : 15'h54A9;
      n_assert++;
      if (b_data !== exp) begin n_fail++; $display("FAIL params_word cnt%0d: got %h expected %h", j, b_data, exp); end
    end
    n_assert++;
    if (b_ohs !== 1'b0) begin n_fail++; $display("FAIL params_hsync: got %b expected 0", b_ohs); end
  endtask

  initial begin
    test_reset();
    test_clock();
    test_ddr_split(24'hA53C96, 12'hC96, 12'hA53);
    test_ddr_split(24'h01F07E, 12'h07E, 12'h01F);
    test_blank();
    test_pattern();
    test_reset_mid();
    test_vsync_same_pixel();
    test_params();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish before 1ms");
    $fatal(1);
  end

endmodule
